mem_writer: RTL and testbench

Sequential block-write engine that fills the data memory (`mem`) with a burst of 32-bit words. It is the writing counterpart to the address-stepping read sweep used in lab benches:
- accepts words over a valid/ready stream;
- drives `address`, `memIn` and `write` to `mem`, stepping the address by 4 per word;
- reports completion with `done`.

It sits between a data source (bench, loader or CPU-side logic) and the `mem` instance, and owns that memory's write port while busy.

---
 rtl/mem_writer_pkg.sv | 17 +
 rtl/mem_wr_addr_gen.sv | 47 ++++
 rtl/mem_writer.sv | 134 +++++++++++++
 tb/tb_mem_writer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_writer_pkg.sv
// Shared types and constants for the mem_writer block-write engine.
// Build option: MEM_WRITER_VERIFY_EN adds a readback CHECK state after every write.
package mem_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_CHECK  = 3'd3,
    ST_STEP   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam int unsigned WORD_BYTES      = 4;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_wr_addr_gen.sv
// Address register and remaining-word counter for mem_writer.
// load takes priority over step; last flags the final word of the burst.
module mem_wr_addr_gen
  import mem_writer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] count,
  output logic [31:0]      address,
  output logic             last
);

  logic [31:0]      address_q, address_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  always_comb begin
    address_d   = address_q;
    remaining_d = remaining_q;
    if (load) begin
      address_d   = base_addr & ADDR_ALIGN_MASK;
      remaining_d = count;
    end else if (step) begin
      // 32-bit add wraps 0xFFFFFFFC to 0 naturally
      address_d   = address_q + 32'(WORD_BYTES);
      remaining_d = remaining_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_q   <= '0;
      remaining_q <= '0;
    end else begin
      address_q   <= address_d;
      remaining_q <= remaining_d;
    end
  end

  assign address = address_q;
  assign last    = (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/mem_writer.sv
// Block-write engine: takes words from a valid/ready stream and writes them to mem at stepping addresses.
// Build option: MEM_WRITER_VERIFY_EN enables the CHECK readback state, read and verify_err.
module mem_writer
  import mem_writer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] count,
  input  logic [31:0]      data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [31:0]      memOut,
  output logic [31:0]      address,
  output logic [31:0]      memIn,
  output logic             read,
  output logic             write,
  output logic             busy,
  output logic             done,
  output logic             verify_err
);

  state_e      state_q, state_d;
  logic [31:0] mem_in_q, mem_in_d;
  logic        write_q, write_d;
  logic        read_q, read_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        data_ready_q, data_ready_d;
  logic        verify_err_q, verify_err_d;
  logic        ag_load, ag_step, ag_last;

  mem_wr_addr_gen #(.CNT_W(CNT_W)) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (ag_load),
    .step      (ag_step),
    .base_addr (base_addr),
    .count     (count),
    .address   (address),
    .last      (ag_last)
  );

  always_comb begin
    state_d      = state_q;
    mem_in_d     = mem_in_q;
    verify_err_d = verify_err_q;
    ag_load      = 1'b0;
    ag_step      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ag_load      = 1'b1;
          verify_err_d = 1'b0;
          state_d      = (count == '0) ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (data_valid) begin
          mem_in_d = data_in;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
`ifdef MEM_WRITER_VERIFY_EN
        state_d = ST_CHECK;
`else
        state_d = ST_STEP;
`endif
      end
      ST_CHECK: begin
`ifdef MEM_WRITER_VERIFY_EN
        if (memOut != mem_in_q) verify_err_d = 1'b1;
`endif
        state_d = ST_STEP;
      end
      ST_STEP: begin
        ag_step = 1'b1;
        state_d = ag_last ? ST_DONE : ST_ACCEPT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // outputs are registered versions of the state being entered
    write_d      = (state_d == ST_WRITE);
    read_d       = (state_d == ST_CHECK);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    data_ready_d = (state_d == ST_ACCEPT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mem_in_q     <= '0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      data_ready_q <= 1'b0;
      verify_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_in_q     <= mem_in_d;
      write_q      <= write_d;
      read_q       <= read_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      data_ready_q <= data_ready_d;
      verify_err_q <= verify_err_d;
    end
  end

  assign memIn      = mem_in_q;
  assign write      = write_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign data_ready = data_ready_q;

`ifdef MEM_WRITER_VERIFY_EN
  assign read       = read_q;
  assign verify_err = verify_err_q;
`else
  logic unused_verify;
  assign unused_verify = ^{memOut, read_q, verify_err_q};
  assign read       = 1'b0;
  assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_writer.sv
// Self-checking bench for mem_writer: behavioural memory plus an expected-image model built from burst rules.
// Honours MEM_WRITER_VERIFY_EN for per-word latency and the readback-error scenario.
module tb_mem_writer;

`ifdef MEM_WRITER_VERIFY_EN
  localparam int CPW = 4;
`else
  localparam int CPW = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  count;
  logic [31:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] memOut;
  logic [31:0] address;
  logic [31:0] memIn;
  logic        read;
  logic        write;
  logic        busy;
  logic        done;
  logic        verify_err;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  logic [31:0] mem_model [logic [31:0]];
  bit          inject_en = 1'b0;
  logic [31:0] inject_addr = 32'h0;

  mem_writer #(.CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .count      (count),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .memOut     (memOut),
    .address    (address),
    .memIn      (memIn),
    .read       (read),
    .write      (write),
    .busy       (busy),
    .done       (done),
    .verify_err (verify_err)
  );

  always #5 clk = ~clk;

  // behavioural mem: write captured on the rising edge
  always @(posedge clk) begin
    if (write === 1'b1) begin
      mem_model[address] = memIn;
      wr_count++;
    end
  end

  always @(negedge clk) begin
    memOut = (mem_model.exists(address) ? mem_model[address] : 32'h0) ^
             ((inject_en && address == inject_addr) ? 32'h0000_0100 : 32'h0);
  end

  task automatic run_burst(input string name, input logic [31:0] base, input logic [31:0] words[$],
                           input int stall_mode, input bit restart_mid, input bit exp_verr);
    int n, idx, stalls, done_cyc, done_cnt, wr0, exp_lat, nstall;
    logic [31:0] abase, ea;
    bit fin;
    n = words.size();
    abase = base & 32'hFFFF_FFFC;
    mem_model.delete();
    idx = 0; stalls = 0; done_cyc = -1; done_cnt = 0; nstall = 0; fin = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = base; count = 8'(n); data_valid = 1'b0;
    wr0 = wr_count;
    for (int c = 1; c <= 3000 && !fin; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (restart_mid && c == 3) begin
        start = 1'b1; base_addr = 32'h0000_5550; count = 8'd7;
      end
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1 || verify_err !== 1'b0) begin
          errors++;
          $display("FAIL %s after_start: busy=%b verify_err=%b required busy=1 verify_err=0", name, busy, verify_err);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c == done_cyc + 2) fin = 1'b1;
      if (data_ready === 1'b1 && idx < n) begin
        if ((stall_mode == 2 && nstall < 5) || (stall_mode == 1 && $urandom_range(0, 3) == 0)) begin
          nstall++; stalls++;
          data_valid = 1'b0; data_in = $urandom;
          ea = abase + 32'(4 * idx);
          checks++;
          if (write !== 1'b0 || address !== ea) begin
            errors++;
            $display("FAIL %s stall: write=%b address=%h required write=0 address=%h", name, write, address, ea);
          end
        end else begin
          data_valid = 1'b1; data_in = words[idx]; idx++;
        end
      end else begin
        data_valid = 1'($urandom_range(0, 1)); data_in = $urandom;
      end
    end
    data_valid = 1'b0;
    exp_lat = CPW * n + 1 + stalls;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s timeout: done never seen within cycle budget", name);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != exp_lat) begin
      errors++;
      $display("FAIL %s done_timing: pulses=%0d at_cycle=%0d required pulses=1 at_cycle=%0d", name, done_cnt, done_cyc, exp_lat);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after: busy=%b required 0", name, busy);
    end
    checks++;
    if (wr_count - wr0 != n) begin
      errors++;
      $display("FAIL %s write_count: got=%0d required=%0d", name, wr_count - wr0, n);
    end
    for (int i = 0; i < n; i++) begin
      ea = abase + 32'(4 * i);
      checks++;
      if (!mem_model.exists(ea) || mem_model[ea] !== words[i]) begin
        errors++;
        $display("FAIL %s mem[%h]: got=%h required=%h", name, ea,
                 mem_model.exists(ea) ? mem_model[ea] : 32'hxxxx_xxxx, words[i]);
      end
    end
    checks++;
    if (verify_err !== exp_verr) begin
      errors++;
      $display("FAIL %s verify_err: got=%b required=%b", name, verify_err, exp_verr);
    end
    if (restart_mid) begin
      checks++;
      if (mem_model.exists(32'h0000_5550)) begin
        errors++;
        $display("FAIL %s ignored_start: mem[5550] written, required untouched", name);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; base_addr = 32'h0; count = 8'h0;
    data_in = 32'h0; data_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({address, memIn, read, write, busy, done, data_ready, verify_err} !== '0) begin
      errors++;
      $display("FAIL reset_values: addr=%h memIn=%h rd=%b wr=%b busy=%b done=%b rdy=%b verr=%b required all 0",
               address, memIn, read, write, busy, done, data_ready, verify_err);
    end
    reset = 1'b0;
    data_valid = 1'b1;
    repeat (2) @(negedge clk);
    data_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || data_ready !== 1'b0 || write !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b rdy=%b wr=%b done=%b required all 0", busy, data_ready, write, done);
    end
  endtask

  task automatic test_basic_burst;
    logic [31:0] q[$];
    for (int i = 0; i < 11; i++) q.push_back(32'h1000 + 32'(i));
    run_burst("basic", 32'd128, q, 0, 1'b0, 1'b0);
  endtask

  task automatic test_alignment;
    logic [31:0] q[$];
    q.push_back(32'hDEAD_BEEF);
    run_burst("align", 32'd131, q, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stall;
    logic [31:0] q[$];
    for (int i = 0; i < 4; i++) q.push_back($urandom);
    run_burst("stall5", 32'h0000_0400, q, 2, 1'b0, 1'b0);
  endtask

  task automatic test_random_bursts;
    logic [31:0] q[$];
    for (int b = 0; b < 4; b++) begin
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) q.push_back($urandom);
      run_burst("random", $urandom, q, 1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_zero_and_ignored_start;
    logic [31:0] q[$];
    run_burst("zero_count", 32'h0000_0800, q, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) q.push_back($urandom);
    run_burst("ignored_start", 32'h0000_0900, q, 0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap;
    logic [31:0] q[$];
    q.push_back(32'h1111_2222);
    q.push_back(32'h3333_4444);
    run_burst("wrap", 32'hFFFF_FFFC, q, 0, 1'b0, 1'b0);
  endtask

  task automatic test_max_count;
    logic [31:0] q[$];
    for (int i = 0; i < 255; i++) q.push_back($urandom);
    run_burst("max_count", 32'h0001_0000, q, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_burst;
    int wr0, idx;
    bit hit;
    mem_model.delete();
    idx = 0; hit = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = 32'h0000_2000; count = 8'd3;
    wr0 = wr_count;
    for (int c = 1; c <= 60 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (write === 1'b1 && wr_count - wr0 == 1) hit = 1'b1;
      else if (data_ready === 1'b1) begin
        data_valid = 1'b1; data_in = 32'hA000_0000 + 32'(idx); idx++;
      end else data_valid = 1'b0;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid timeout: second write never seen");
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({address, memIn, read, write, busy, done, data_ready, verify_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: addr=%h memIn=%h rd=%b wr=%b busy=%b done=%b rdy=%b verr=%b required all 0",
               address, memIn, read, write, busy, done, data_ready, verify_err);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0; data_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_count - wr0 != 1) begin
      errors++;
      $display("FAIL reset_mid_state: busy=%b writes=%0d required busy=0 writes=1", busy, wr_count - wr0);
    end
    checks++;
    if (!mem_model.exists(32'h2000) || mem_model[32'h2000] !== 32'hA000_0000 || mem_model.exists(32'h2004)) begin
      errors++;
      $display("FAIL reset_mid_mem: word0_present=%0d word1_present=%0d required 1 and 0",
               mem_model.exists(32'h2000), mem_model.exists(32'h2004));
    end
  endtask

`ifdef MEM_WRITER_VERIFY_EN
  task automatic test_verify;
    logic [31:0] q[$];
    for (int i = 0; i < 6; i++) q.push_back($urandom);
    run_burst("verify_match", 32'h0000_3000, q, 1, 1'b0, 1'b0);
    inject_en = 1'b1; inject_addr = 32'h0000_3000 + 32'd12;
    run_burst("verify_mismatch", 32'h0000_3000, q, 0, 1'b0, 1'b1);
    inject_en = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (verify_err !== 1'b1) begin
      errors++;
      $display("FAIL verify_sticky: verify_err=%b required 1", verify_err);
    end
    run_burst("verify_cleared", 32'h0000_3100, q, 0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_burst();
    test_alignment();
    test_stall();
    test_random_bursts();
    test_zero_and_ignored_start();
    test_wrap();
    test_max_count();
    test_reset_mid_burst();
`ifdef MEM_WRITER_VERIFY_EN
    test_verify();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
